// File: rtl/expipe_pkg.sv
// Execution-pipeline types: branch-unit resolution entry.
package expipe_pkg;
  import len5_pkg::*;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
    logic            taken;
    logic            mispredict;
  } bu_res_t;
endpackage

// File: rtl/len5_pkg.sv
// Core-wide architectural constants shared across the LEN5 pipeline.
package len5_pkg;
  localparam int unsigned XLEN = 32;
endpackage

// File: rtl/branch_res_fifo.sv
// Circular FIFO of branch resolutions; flush and reset empty it without touching storage.
module branch_res_fifo
  import expipe_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = bu_res_t
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  entry_t                   data_i,
  input  logic                     pop_i,
  output entry_t                   head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   head_q, tail_q;
  logic [CW-1:0]   count_q;
  logic            do_push, do_pop;

  always_comb begin
    empty_o = (count_q == '0);
    full_o  = (count_q == CW'(DEPTH));
    do_pop  = pop_i & ~empty_o;
    // A pop in the same cycle frees the slot, so a push at full still lands.
    do_push = push_i & (~full_o | do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) tail_q <= tail_q + 1'b1;
      if (do_pop)  head_q <= head_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i && do_push) mem_q[tail_q] <= data_i;
  end

  assign head_o  = mem_q[head_q];
  assign count_o = count_q;
endmodule

// File: rtl/branch_res_buffer.sv
// Buffers branch resolutions toward the predictor update port and raises fetch redirects.
// Optional same-cycle bypass into an empty buffer: define BRANCH_RES_BYPASS_EN.
module branch_res_buffer
  import len5_pkg::*;
  import expipe_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   res_valid_i,
  input  logic [XLEN-1:0]        res_pc_i,
  input  logic [XLEN-1:0]        res_target_i,
  input  logic                   res_taken_i,
  input  logic                   res_mispredict_i,
  output logic                   upd_valid_o,
  input  logic                   upd_ready_i,
  output logic [XLEN-1:0]        upd_pc_o,
  output logic [XLEN-1:0]        upd_target_o,
  output logic                   upd_taken_o,
  output logic                   upd_mispredict_o,
  output logic                   redirect_valid_o,
  output logic [XLEN-1:0]        redirect_pc_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   overflow_o
);
  bu_res_t res_in, head, upd_sel;
  logic    enq_req, push, pop, empty, drop;

  branch_res_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (bu_res_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (push),
    .data_i  (res_in),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (count_o),
    .full_o  (full_o),
    .empty_o (empty)
  );

  always_comb begin
    res_in.pc         = res_pc_i;
    res_in.target     = res_target_i;
    res_in.taken      = res_taken_i;
    res_in.mispredict = res_mispredict_i;
    enq_req           = res_valid_i & ~flush_i;
`ifdef BRANCH_RES_BYPASS_EN
    if (empty && enq_req) begin
      upd_valid_o = 1'b1;
      upd_sel     = res_in;
      push        = ~upd_ready_i;
      pop         = 1'b0;
    end else begin
      upd_valid_o = ~empty;
      upd_sel     = head;
      push        = enq_req;
      pop         = ~empty & upd_ready_i;
    end
`else
    upd_valid_o = ~empty;
    upd_sel     = head;
    push        = enq_req;
    pop         = ~empty & upd_ready_i;
`endif
    drop = push & full_o & ~pop;
    // Data fields read as zero whenever nothing is offered.
    upd_pc_o         = upd_valid_o ? upd_sel.pc         : '0;
    upd_target_o     = upd_valid_o ? upd_sel.target     : '0;
    upd_taken_o      = upd_valid_o & upd_sel.taken;
    upd_mispredict_o = upd_valid_o & upd_sel.mispredict;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overflow_o       <= 1'b0;
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= '0;
    end else begin
      if (drop) overflow_o <= 1'b1;
      // Redirect is independent of whether the entry was stored or dropped.
      redirect_valid_o <= enq_req & res_mispredict_i;
      if (enq_req && res_mispredict_i)
        redirect_pc_o <= res_taken_i ? res_target_i : res_pc_i + XLEN'(4);
    end
  end
endmodule

// File: tb/tb_branch_res_buffer.sv
// Directed + random scoreboard bench for branch_res_buffer (DEPTH=4).
module tb_branch_res_buffer;
  import len5_pkg::*;
  import expipe_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic                   clk = 1'b0;
  logic                   rst, flush, res_valid, res_taken, res_mis, upd_ready;
  logic [XLEN-1:0]        res_pc, res_target;
  logic                   upd_valid, upd_taken, upd_mis, redirect_valid, full, overflow;
  logic [XLEN-1:0]        upd_pc, upd_target, redirect_pc;
  logic [$clog2(DEPTH):0] count;

  bu_res_t         exp_q [$];
  logic            exp_ov, exp_rv;
  logic [XLEN-1:0] exp_rpc;
  int              checks = 0;
  int              errors = 0;

  always #5 clk = ~clk;

  branch_res_buffer #(.DEPTH(DEPTH)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .flush_i          (flush),
    .res_valid_i      (res_valid),
    .res_pc_i         (res_pc),
    .res_target_i     (res_target),
    .res_taken_i      (res_taken),
    .res_mispredict_i (res_mis),
    .upd_valid_o      (upd_valid),
    .upd_ready_i      (upd_ready),
    .upd_pc_o         (upd_pc),
    .upd_target_o     (upd_target),
    .upd_taken_o      (upd_taken),
    .upd_mispredict_o (upd_mis),
    .redirect_valid_o (redirect_valid),
    .redirect_pc_o    (redirect_pc),
    .count_o          (count),
    .full_o           (full),
    .overflow_o       (overflow)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int sz;
    sz = exp_q.size();
    check("count", 64'(count), 64'(sz));
    check("full", 64'(full), 64'(sz == DEPTH));
    check("overflow", 64'(overflow), 64'(exp_ov));
    check("upd_valid", 64'(upd_valid), 64'(sz != 0));
    if (sz != 0) begin
      check("upd_pc", 64'(upd_pc), 64'(exp_q[0].pc));
      check("upd_target", 64'(upd_target), 64'(exp_q[0].target));
      check("upd_taken", 64'(upd_taken), 64'(exp_q[0].taken));
      check("upd_mispredict", 64'(upd_mis), 64'(exp_q[0].mispredict));
    end
    check("redirect_valid", 64'(redirect_valid), 64'(exp_rv));
    if (exp_rv) check("redirect_pc", 64'(redirect_pc), 64'(exp_rpc));
  endtask

  // Model the clock edge from the inputs currently driven, then observe 1ns later.
  task automatic tick(input bit chk);
    bit      m_pop, m_enq, m_full;
    bu_res_t e;
    m_full       = (exp_q.size() == DEPTH);
    m_pop        = (exp_q.size() != 0) && upd_ready;
    m_enq        = res_valid && !flush;
    e.pc         = res_pc;
    e.target     = res_target;
    e.taken      = res_taken;
    e.mispredict = res_mis;
    @(posedge clk);
    #1;
    if (rst) begin
      exp_q.delete();
      exp_ov  = 1'b0;
      exp_rv  = 1'b0;
      exp_rpc = '0;
    end else if (flush) begin
      exp_q.delete();
      exp_rv = 1'b0;
    end else begin
      if (m_pop) void'(exp_q.pop_front());
      if (m_enq) begin
        if (!m_full || m_pop) exp_q.push_back(e);
        else exp_ov = 1'b1;
      end
      exp_rv = m_enq && res_mis;
      if (exp_rv) exp_rpc = res_taken ? res_target : res_pc + 32'd4;
    end
    if (chk) check_all();
  endtask

  task automatic drive(input logic v, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] tgt,
                       input logic tk, input logic mp);
    res_valid  = v;
    res_pc     = pc;
    res_target = tgt;
    res_taken  = tk;
    res_mis    = mp;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; upd_ready = 1'b0;
    drive(1'b1, 32'h55, 32'h66, 1'b1, 1'b1);
    exp_ov = 1'b0; exp_rv = 1'b0; exp_rpc = '0;
    tick(0);
    tick(1);
    check("rst_upd_pc", 64'(upd_pc), 64'd0);
    check("rst_redirect_pc", 64'(redirect_pc), 64'd0);
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    tick(1);

`ifdef BRANCH_RES_BYPASS_EN
    upd_ready = 1'b1;
    drive(1'b1, 32'h10, 32'h20, 1'b1, 1'b0);
    #1;
    check("byp_valid", 64'(upd_valid), 64'd1);
    check("byp_pc", 64'(upd_pc), 64'h10);
    tick(0);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #1;
    check("byp_count", 64'(count), 64'd0);
    upd_ready = 1'b0;
    drive(1'b1, 32'h14, 32'h24, 1'b0, 1'b0);
    #1;
    check("byp_stall_pc", 64'(upd_pc), 64'h14);
    tick(0);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #1;
    check("byp_stored_count", 64'(count), 64'd1);
    check("byp_stored_pc", 64'(upd_pc), 64'h14);
`else
    // Single entry passes through with one cycle latency.
    upd_ready = 1'b1;
    drive(1'b1, 32'h1000, 32'h2000, 1'b1, 1'b0);
    tick(1);
    check("lat_valid", 64'(upd_valid), 64'd1);
    check("lat_pc", 64'(upd_pc), 64'h1000);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    tick(1);
    check("lat_count", 64'(count), 64'd0);

    // Overflow: five results into a stalled buffer.
    upd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h100 + 32'(4 * i), 32'h900, 1'b0, 1'b0);
      tick(1);
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    tick(1);
    check("ovf_count", 64'(count), 64'd4);
    check("ovf_full", 64'(full), 64'd1);
    check("ovf_flag", 64'(overflow), 64'd1);
    check("ovf_head", 64'(upd_pc), 64'h100);
    tick(1);
    check("ovf_head_stable", 64'(upd_pc), 64'h100);

    // Reset mid-transfer with a result presented.
    rst = 1'b1; upd_ready = 1'b1;
    drive(1'b1, 32'h700, 32'h0, 1'b0, 1'b1);
    tick(1);
    check("midrst_valid", 64'(upd_valid), 64'd0);
    check("midrst_ovf", 64'(overflow), 64'd0);
    rst = 1'b0;

    // Full with simultaneous dequeue: no drop.
    upd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h200 + 32'(4 * i), 32'h0, 1'b0, 1'b0);
      tick(1);
    end
    upd_ready = 1'b1;
    drive(1'b1, 32'h210, 32'h0, 1'b0, 1'b0);
    tick(1);
    check("fullrw_count", 64'(count), 64'd4);
    check("fullrw_ovf", 64'(overflow), 64'd0);
    check("fullrw_head", 64'(upd_pc), 64'h204);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick(1);

    // Redirects: not-taken, single-cycle pulse, taken, back-to-back, wrap.
    drive(1'b1, 32'h80, 32'h0, 1'b0, 1'b1);
    tick(1);
    check("redir_nt_v", 64'(redirect_valid), 64'd1);
    check("redir_nt_pc", 64'(redirect_pc), 64'h84);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    tick(1);
    check("redir_pulse", 64'(redirect_valid), 64'd0);
    drive(1'b1, 32'h80, 32'h400, 1'b1, 1'b1);
    tick(1);
    check("redir_tk_pc", 64'(redirect_pc), 64'h400);
    drive(1'b1, 32'h300, 32'h0, 1'b0, 1'b1);
    tick(1);
    check("redir_b2b_v", 64'(redirect_valid), 64'd1);
    check("redir_b2b_pc", 64'(redirect_pc), 64'h304);
    drive(1'b1, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b1);
    tick(1);
    check("redir_wrap_pc", 64'(redirect_pc), 64'h0);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick(1);

    // Redirect still fires when the entry is dropped at full.
    upd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h400 + 32'(4 * i), 32'h0, 1'b0, 1'b0);
      tick(1);
    end
    drive(1'b1, 32'h500, 32'h0, 1'b0, 1'b1);
    tick(1);
    check("drop_redir_v", 64'(redirect_valid), 64'd1);
    check("drop_redir_pc", 64'(redirect_pc), 64'h504);
    check("drop_count", 64'(count), 64'd4);

    // Flush with a mispredict presented.
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    tick(1);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h600 + 32'(4 * i), 32'h0, 1'b0, 1'b0);
      tick(1);
    end
    flush = 1'b1;
    drive(1'b1, 32'h640, 32'h0, 1'b0, 1'b1);
    tick(1);
    check("flush_count", 64'(count), 64'd0);
    check("flush_redir", 64'(redirect_valid), 64'd0);
    check("flush_valid", 64'(upd_valid), 64'd0);
    flush = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    tick(1);

    // Random traffic against the scoreboard.
    for (int i = 0; i < 200; i++) begin
      upd_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      drive(1'($urandom_range(0, 1)), {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
            $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tick(1);
    end
    flush = 1'b0;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_res_buffer.md
BRANCH_RES_BUFFER -- requirements
Module: branch_res_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered resolution entries; SHALL be a power of 2, ≥2.
REQ-002 clk_i  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_i  in  1  reset, synchronous, active-high.
REQ-004 flush_i  in  1  pipeline flush from commit.
REQ-005 res_valid_i  in  1  branch unit result valid; no back-pressure toward the branch unit.
REQ-006 res_pc_i  in  XLEN  resolved branch PC.
REQ-007 res_target_i  in  XLEN  resolved target.
REQ-008 res_taken_i  in  1  resolved direction.
REQ-009 res_mispredict_i  in  1  prediction was wrong.
REQ-010 upd_valid_o / upd_ready_i  out/in  1  handshake to the branch-predictor update port.
REQ-011 upd_pc_o, upd_target_o  out  XLEN; upd_taken_o, upd_mispredict_o  out  1  head entry fields.
REQ-012 redirect_valid_o  out  1; redirect_pc_o  out  XLEN  fetch redirect.
REQ-013 count_o  out  $clog2(DEPTH)+1  occupancy; full_o  out  1; overflow_o  out  1  sticky drop flag.

Function
REQ-014 Circular FIFO, head/tail pointers wrap modulo DEPTH; count_o SHALL equal stored entries, 0..DEPTH.
REQ-015 Enqueue when res_valid_i=1, flush_i=0 and (not full, or dequeue in same cycle); entry visible at head no earlier than next cycle (default build).
REQ-016 Dequeue when upd_valid_o=1 and upd_ready_i=1; upd_valid_o = (count_o≠0); head fields SHALL stay stable while upd_valid_o=1 and upd_ready_i=0.
REQ-017 Simultaneous enqueue and dequeue at full SHALL succeed; count_o unchanged.
REQ-018 res_valid_i=1 at full with no dequeue: entry dropped, count unchanged, overflow_o SHALL set next cycle and hold until reset.
REQ-019 Redirect: cycle after res_valid_i=1 & res_mispredict_i=1 & flush_i=0, redirect_valid_o=1 for exactly one cycle; redirect_pc_o = res_taken_i ? res_target_i : res_pc_i+4 (XLEN wrap-around).
REQ-020 Redirect SHALL be generated even when the entry is dropped at full.
REQ-021 Back-to-back mispredicts SHALL yield back-to-back one-cycle redirects, each with its own PC.
REQ-022 flush_i=1: next cycle count_o=0, upd_valid_o=0, pending redirect cancelled; same-cycle res_valid_i discarded; overflow_o unaffected.
REQ-023 full_o = (count_o==DEPTH), combinational from state.

Reset
REQ-024 rst_i=1 at a clock edge: pointers 0, count_o=0, full_o=0, upd_valid_o=0, redirect_valid_o=0, overflow_o=0, data outputs 0; reset SHALL override flush_i and res_valid_i.
REQ-025 Reset asserted mid-transfer SHALL discard all entries; no upd_valid_o in the cycle after reset.

Configuration
REQ-026 Macro BRANCH_RES_BYPASS_EN defined: when count_o=0 and res_valid_i=1 and flush_i=0, upd_valid_o SHALL assert same cycle with res_* fields; if upd_ready_i=1 entry not stored, else stored.
REQ-027 Macro undefined: no combinational path from res_* to upd_*; minimum latency one cycle.

Structure
REQ-028 Entry typedef bu_res_t (pc, target, taken, mispredict) SHALL live in expipe_pkg; XLEN from len5_pkg.
REQ-029 Storage and pointer/counter logic SHALL be sub-module branch_res_fifo (parameter DEPTH, type bu_res_t); redirect logic in top.

Verification
REQ-030 Enqueue pc=0x1000,target=0x2000,taken=1, upd_ready_i=1 -> next cycle upd_valid_o=1, upd_pc_o=0x1000; following cycle count_o=0.
REQ-031 DEPTH=4, upd_ready_i=0, 5 results -> count_o=4, full_o=1, overflow_o=1, head pc = first.
REQ-032 Mispredict pc=0x80, taken=0 -> next cycle redirect_valid_o=1, redirect_pc_o=0x84, one cycle only; taken=1,target=0x400 -> 0x400.
REQ-033 Full, res_valid_i with upd_ready_i=1 same cycle -> count stays 4, overflow_o stays 0.
REQ-034 3 entries queued, flush_i with res_valid_i mispredict -> next cycle count_o=0, redirect_valid_o=0.
REQ-035 With BRANCH_RES_BYPASS_EN, empty, res_valid_i pc=0x10, upd_ready_i=1 -> upd_valid_o=1 same cycle, count_o stays 0.
